// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator computer: opcodes, sequencer
// states and ALU operation codes.
package cpu_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_STA = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_F_ADDR = 3'd1,
    ST_F_MEM  = 3'd2,
    ST_DECODE = 3'd3,
    ST_X_ADDR = 3'd4,
    ST_X_MEM  = 3'd5,
    ST_HALTED = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Alu selection for the accumulator-loading opcodes; STA never loads ACC.
  function automatic logic [1:0] alu_for(logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for memory handshakes: counts cycles spent waiting for mem_rdy and
// flags the last allowed cycle. TIMEOUT=0 disables it entirely.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  // Saturates at LAST; the sequencer leaves the wait state before it matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT > 0) && (count == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator computer. Outputs
// are decoded from the state, IR, zero flag and mem_rdy.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] instr,
  input  logic              zero,
  input  logic              mem_rdy,
  output logic              pc_inc,
  output logic              jmp,
  output logic [ADDR_W-1:0] jmp_add,
  output logic              mar_load,
  output logic              mar_src,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              ir_load,
  output logic              acc_load,
  output logic [1:0]        alu_op,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state_o
);

  state_t            state;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              in_mem;
  logic              wd_expired;

  assign opcode  = instr[DATA_W-1 -: 3];
  assign operand = instr[ADDR_W-1:0];
  assign in_mem  = (state == ST_F_MEM) || (state == ST_X_MEM);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!in_mem),
    .count_en (in_mem && !mem_rdy),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (run) state <= ST_F_ADDR;
        ST_F_ADDR: state <= ST_F_MEM;
        ST_F_MEM: begin
          // A ready on the final allowed cycle still completes the access.
          if (mem_rdy)         state <= ST_DECODE;
          else if (wd_expired) state <= ST_FAULT;
        end
        ST_DECODE: begin
          case (opcode)
            OP_NOP, OP_JMP, OP_JZ: state <= ST_F_ADDR;
            OP_HLT:                state <= ST_HALTED;
            default:               state <= ST_X_ADDR;
          endcase
        end
        ST_X_ADDR: state <= ST_X_MEM;
        ST_X_MEM: begin
          if (mem_rdy)         state <= ST_F_ADDR;
          else if (wd_expired) state <= ST_FAULT;
        end
        ST_HALTED: state <= ST_HALTED;
        ST_FAULT:  state <= ST_FAULT;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_inc   = 1'b0;
    jmp      = 1'b0;
    jmp_add  = '0;
    mar_load = 1'b0;
    mar_src  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_load  = 1'b0;
    acc_load = 1'b0;
    alu_op   = ALU_PASS;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      ST_F_ADDR: mar_load = 1'b1;
      ST_F_MEM: begin
        mem_rd  = 1'b1;
        ir_load = mem_rdy;
        pc_inc  = mem_rdy;
      end
      ST_DECODE: begin
        if (opcode == OP_JMP)     jmp = 1'b1;
        else if (opcode == OP_JZ) jmp = zero;
        if (jmp) jmp_add = operand;
      end
      ST_X_ADDR: begin
        mar_load = 1'b1;
        mar_src  = 1'b1;
      end
      ST_X_MEM: begin
        if (opcode == OP_STA) begin
          mem_wr = 1'b1;
        end else begin
          mem_rd   = 1'b1;
          acc_load = mem_rdy;
          if (mem_rdy) alu_op = alu_for(opcode);
        end
      end
      ST_HALTED: halted = 1'b1;
      ST_FAULT:  fault  = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
